// File: rtl/fp_pkg.sv
// Shared single-precision constants and the squaring-unit state encoding.
package fp_pkg;

    localparam int MANT_W = 23;
    localparam int EXP_W  = 8;
    localparam int BIAS   = 127;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2
    } state_t;

endpackage

// File: rtl/mul24_shift_add.sv
// Sequential unsigned multiplier: one partial product per cycle, W iterations after load.
module mul24_shift_add #(
    parameter int W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   product,
    output logic             last
);

    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [4:0]     count;
    logic           active;
    logic [W:0]     sum;

    // Carry out of the upper-half add becomes the new MSB after the shift.
    always_comb begin
        sum = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= {sum, acc[W-1:1]};
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (count == 5'(W - 1)) active <= 1'b0;
        end
    end

    assign product = acc;
    assign last    = active && (count == 5'(W - 1));

endmodule

// File: rtl/fp_square.sv
// IEEE-754 single-precision squaring unit with start/done handshake and fixed 25-cycle latency.
module fp_square #(
    parameter int MANT_W = fp_pkg::MANT_W,
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic        sq_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    output logic        busy,
    output logic        done,
    output logic [31:0] Out
);

    import fp_pkg::*;

    state_t             state, state_next;
    logic               load;
    logic [EXP_W-1:0]   exp_q;
    logic [MANT_W-1:0]  mant_q;
    logic [MANT_W:0]    mcand;
    logic [47:0]        prod;
    logic               mul_last;
    logic signed [9:0]  e_base;
    logic signed [9:0]  e_norm;
    logic [MANT_W-1:0]  mant_norm;
    logic [31:0]        result;
    logic               unused_sign;

    // The square is always non-negative, so the operand sign never reaches the result.
    assign unused_sign = A[31];

    assign mcand = {|A[30:23], A[22:0]};

    mul24_shift_add #(.W(MANT_W + 1)) u_mul (
        .clk     (sq_clk),
        .reset   (reset),
        .load    (load),
        .a       (mcand),
        .b       (mcand),
        .product (prod),
        .last    (mul_last)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: if (start) begin
                load       = 1'b1;
                state_next = MULT;
            end
            MULT:    if (mul_last) state_next = NORM;
            NORM:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Product of two [1,2) mantissas lies in [1,4); P[47] selects the extra exponent step.
    always_comb begin
        e_base    = 10'(signed'({2'b00, exp_q, 1'b0})) - 10'(BIAS);
        e_norm    = e_base + (prod[47] ? 10'sd1 : 10'sd0);
        mant_norm = prod[47] ? prod[46:24] : prod[45:23];
        if (exp_q == '1 && mant_q != '0) result = FP_QNAN;
        else if (exp_q == '1)            result = FP_PINF;
        else if (exp_q == '0)            result = FP_ZERO;
        else if (e_norm >= 10'sd255)     result = FP_PINF;
        else if (e_norm <= 10'sd0)       result = FP_ZERO;
        else                             result = {1'b0, e_norm[7:0], mant_norm};
    end

    always_ff @(posedge sq_clk) begin
        if (reset) begin
            state  <= IDLE;
            exp_q  <= '0;
            mant_q <= '0;
            done   <= 1'b0;
            Out    <= FP_ZERO;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (load) begin
                exp_q  <= A[30:23];
                mant_q <= A[22:0];
            end
            if (state == NORM) begin
                Out  <= result;
                done <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
